// File: rtl/pd_scan_pkg.sv
// ----------------------------------------------------------------------------
// pd_scan_pkg
// Shared constants and types for the photodiode beam scanner.
//   N_CH        number of photodiode channels handled by the scanner
//   CH_W        width of a channel index
//   FIFO_DEPTH  entries in the optional event FIFO
//   FIFO_PTR_W  width of a FIFO read/write pointer
//   pd_event_t  one note event: channel index plus beam state
//               (on = 1 means beam broken, on = 0 means beam restored)
// ----------------------------------------------------------------------------
package pd_scan_pkg;

    localparam int N_CH       = 8;
    localparam int CH_W       = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_PTR_W = 3;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            on;
    } pd_event_t;

endpackage

// File: rtl/pd_debounce.sv
// ----------------------------------------------------------------------------
// pd_debounce
// One photodiode channel: a 2-flop synchroniser followed by a persistence
// counter. The stable output only changes once the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   raw     unsynchronised photodiode pin (1 = beam broken)
//   stable  debounced beam state
// ----------------------------------------------------------------------------
module pd_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);
    import pd_scan_pkg::*;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The toggle fires on the edge where the count would reach
    // DEBOUNCE_CYCLES, so the register is compared against one less.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser: the raw pin is asynchronous to clk, so nothing
    // else may look at it before it has passed through both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Persistence counter. Any cycle where the synchronised input agrees with
    // the accepted state restarts the count, so a glitch shorter than
    // DEBOUNCE_CYCLES can never flip the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_2 == stable) begin
            cnt <= '0;
        end else if (cnt == LAST_COUNT) begin
            stable <= ~stable;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pd_beam_scanner.sv
// ----------------------------------------------------------------------------
// pd_beam_scanner
// Debounces eight photodiode channels and turns every accepted change of beam
// state into a note-on / note-off event delivered over a valid/ready port.
// The lowest-numbered channel whose debounced state differs from what was
// last reported wins each cycle; a change that reverts before it is issued
// cancels itself and produces no event.
//
// Build option:
//   PD_EVENT_FIFO_EN  defined   -> 8-entry first-word-fall-through event FIFO
//                     undefined -> single holding register (default)
//
// Ports:
//   clk_clk        50 MHz system clock
//   reset_reset_n  asynchronous active-low reset
//   pd_raw         unsynchronised photodiode pins, 1 = beam broken
//   enable         1 = generate events, 0 = silently absorb changes
//   pd_stable      debounced beam state per channel
//   evt_valid      an event is presented
//   evt_ready      consumer accepts the presented event
//   evt_ch         channel index of the presented event
//   evt_on         1 = beam broken (note on), 0 = beam restored (note off)
// ----------------------------------------------------------------------------
module pd_beam_scanner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int N_CH            = 8
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    input  logic [N_CH-1:0] pd_raw,
    input  logic            enable,
    output logic [N_CH-1:0] pd_stable,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [2:0]      evt_ch,
    output logic            evt_on
);
    import pd_scan_pkg::*;

    logic [N_CH-1:0] reported;
    logic [N_CH-1:0] pending;
    logic            issue_any;
    logic [CH_W-1:0] issue_ch;
    logic            issue;
    logic            space;
    logic            pop;
    pd_event_t       issue_evt;

    // One debouncer per photodiode channel.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        pd_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk_clk),
            .rst_n (reset_reset_n),
            .raw   (pd_raw[gi]),
            .stable(pd_stable[gi])
        );
    end

    // A channel needs reporting whenever its debounced state differs from the
    // state last handed to the consumer.
    assign pending = pd_stable ^ reported;

    // Priority pick: scanning from the top down lets the lowest pending
    // channel overwrite any higher one, so channel 0 always wins.
    always_comb begin
        issue_any = 1'b0;
        issue_ch  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                issue_any = 1'b1;
                issue_ch  = CH_W'(i);
            end
        end
    end

    assign issue_evt.ch = issue_ch;
    assign issue_evt.on = pd_stable[issue_ch];
    assign pop          = evt_valid & evt_ready;
    assign issue        = enable & issue_any & space;

    // Reported-state register. With events disabled it simply follows the
    // debounced state, so changes made while disabled are absorbed rather
    // than replayed once events are re-enabled.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            reported <= '0;
        end else if (!enable) begin
            reported <= pd_stable;
        end else if (issue) begin
            reported[issue_ch] <= pd_stable[issue_ch];
        end
    end

`ifdef PD_EVENT_FIFO_EN

    localparam logic [FIFO_PTR_W:0] FULL_COUNT = (FIFO_PTR_W + 1)'(FIFO_DEPTH);

    pd_event_t             fifo_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic [FIFO_PTR_W:0]   count;

    // A full FIFO still takes a new event when the head leaves this cycle.
    assign space     = (count != FULL_COUNT) | pop;
    assign evt_valid = (count != '0);
    assign evt_ch    = fifo_mem[rd_ptr].ch;
    assign evt_on    = fifo_mem[rd_ptr].on;

    // First-word-fall-through storage: the head entry is always on the
    // outputs, and the memory is cleared on reset so evt_ch/evt_on read 0.
    // Pointers wrap on their own because the depth is a power of two.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (issue) begin
                fifo_mem[wr_ptr] <= issue_evt;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({issue, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`else

    // The holding register has room when empty or when its event is
    // leaving this very cycle.
    assign space = ~evt_valid | evt_ready;

    // Single holding register. A new event always takes priority over
    // clearing, which is what lets a pop and a push share one cycle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_on    <= 1'b0;
        end else if (issue) begin
            evt_valid <= 1'b1;
            evt_ch    <= issue_evt.ch;
            evt_on    <= issue_evt.on;
        end else if (pop) begin
            evt_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_pd_beam_scanner.sv
// ----------------------------------------------------------------------------
// tb_pd_beam_scanner
// Self-checking bench for pd_beam_scanner with a short debounce window.
// A reference model derives the debounced state from the history of raw
// samples and predicts every event into a queue; a monitor compares the DUT
// against that queue every cycle. Works with either output-stage build.
// ----------------------------------------------------------------------------
module tb_pd_beam_scanner;
    import pd_scan_pkg::*;

    localparam int DEB = 4;
`ifdef PD_EVENT_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic       clk_clk       = 1'b0;
    logic       reset_reset_n = 1'b1;
    logic [7:0] pd_raw        = 8'h00;
    logic       enable        = 1'b0;
    logic       evt_ready     = 1'b0;
    logic [7:0] pd_stable;
    logic       evt_valid;
    logic [2:0] evt_ch;
    logic       evt_on;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state.
    pd_event_t  exp_q[$];
    logic [7:0] raw_hist[$];
    logic [7:0] m_stable   = 8'h00;
    logic [7:0] m_reported = 8'h00;

    pd_beam_scanner #(
        .DEBOUNCE_CYCLES(DEB),
        .N_CH           (N_CH)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .pd_raw       (pd_raw),
        .enable       (enable),
        .pd_stable    (pd_stable),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ch       (evt_ch),
        .evt_on       (evt_on)
    );

    always #10 clk_clk = ~clk_clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive inputs right after an edge, then let the given number of edges pass.
    task automatic applyStimulus(input logic [7:0] raw, input logic en,
                                 input logic rdy, input int cycles);
        pd_raw    = raw;
        enable    = en;
        evt_ready = rdy;
        repeat (cycles) @(posedge clk_clk);
        #1;
    endtask

    // Raw value of channel c as sampled idx entries into the history,
    // treating anything before reset as 0.
    function automatic logic histBit(input int idx, input int c);
        logic [7:0] v;
        if (idx < 0) return 1'b0;
        v = raw_hist[idx];
        return v[c];
    endfunction

    // Advance the model over the coming clock edge. Pops/pushes describe
    // what the consumer and scanner do; the debounced state flips once the
    // last DEB synchronised samples (raw delayed by two edges) all disagree.
    task automatic modelStep();
        logic       pop;
        logic       room;
        logic       found;
        int         pick;
        logic [7:0] next_stable;
        logic       all_differ;
        pd_event_t  ev;
        pd_event_t  dropped;

        pop  = evt_ready && (exp_q.size() != 0);
        room = (exp_q.size() < CAP) || pop;
        if (pop) dropped = exp_q.pop_front();

        found = 1'b0;
        pick  = 0;
        for (int c = 0; c < 8; c++) begin
            if (!found && (m_stable[c] != m_reported[c])) begin
                found = 1'b1;
                pick  = c;
            end
        end
        if (!enable) begin
            m_reported = m_stable;
        end else if (found && room) begin
            ev.ch = 3'(pick);
            ev.on = m_stable[pick];
            exp_q.push_back(ev);
            m_reported[pick] = m_stable[pick];
        end

        raw_hist.push_back(pd_raw);
        if (raw_hist.size() > DEB + 2) void'(raw_hist.pop_front());
        next_stable = m_stable;
        for (int c = 0; c < 8; c++) begin
            all_differ = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (histBit(raw_hist.size() - 3 - j, c) == m_stable[c]) all_differ = 1'b0;
            end
            if (all_differ) next_stable[c] = ~m_stable[c];
        end
        m_stable = next_stable;
    endtask

    // Monitor: compares the DUT against the model mid-cycle, then advances
    // the model over the next edge using the inputs that edge will see.
    always @(negedge clk_clk) begin
        if (!reset_reset_n) begin
            exp_q.delete();
            raw_hist.delete();
            m_stable   = 8'h00;
            m_reported = 8'h00;
            checkOutput("rst_evt_valid", evt_valid, 0);
            checkOutput("rst_pd_stable", pd_stable, 0);
        end else begin
            checkOutput("pd_stable", pd_stable, m_stable);
            checkOutput("evt_valid", evt_valid, exp_q.size() != 0);
            if (evt_valid && exp_q.size() != 0) begin
                checkOutput("evt_ch", evt_ch, exp_q[0].ch);
                checkOutput("evt_on", evt_on, exp_q[0].on);
            end
            modelStep();
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] r;
        int         drain;

        #5 reset_reset_n = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1;
        checkOutput("reset_evt_valid", evt_valid, 0);
        checkOutput("reset_evt_ch", evt_ch, 0);
        checkOutput("reset_evt_on", evt_on, 0);
        checkOutput("reset_pd_stable", pd_stable, 0);
        reset_reset_n = 1'b1;
        applyStimulus(8'h00, 1'b1, 1'b1, 10);

        $display("[TB] debounce latency on channel 2");
        applyStimulus(8'h04, 1'b1, 1'b1, 5);
        checkOutput("latency_edge5", pd_stable[2], 0);
        applyStimulus(8'h04, 1'b1, 1'b1, 1);
        checkOutput("latency_edge6", pd_stable[2], 1);
        applyStimulus(8'h04, 1'b1, 1'b1, 8);

        $display("[TB] three-cycle glitch on channel 5");
        applyStimulus(8'h24, 1'b1, 1'b1, 3);
        applyStimulus(8'h04, 1'b1, 1'b1, 12);
        checkOutput("glitch_pd_stable", pd_stable, 8'h04);

        $display("[TB] simultaneous change on channels 0 and 7");
        applyStimulus(8'h00, 1'b1, 1'b1, 12);
        applyStimulus(8'h81, 1'b1, 1'b1, 12);

        $display("[TB] backpressure with ten changes");
        applyStimulus(8'h7E, 1'b1, 1'b0, 12);
        applyStimulus(8'h7D, 1'b1, 1'b0, 12);
        applyStimulus(8'h7D, 1'b1, 1'b1, 25);

        $display("[TB] cancellation under backpressure and disabled events");
        applyStimulus(8'h00, 1'b1, 1'b1, 20);
        applyStimulus(8'h01, 1'b1, 1'b0, 10);
        applyStimulus(8'h11, 1'b1, 1'b0, 10);
        applyStimulus(8'h01, 1'b1, 1'b0, 10);
        applyStimulus(8'h01, 1'b1, 1'b1, 10);
        applyStimulus(8'h21, 1'b0, 1'b1, 12);
        checkOutput("disabled_pd_stable", pd_stable, 8'h21);
        applyStimulus(8'h21, 1'b1, 1'b1, 10);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 3000; k++) begin
            r = pd_raw;
            if ($urandom_range(0, 7) == 0) r[$urandom_range(0, 7)] ^= 1'b1;
            applyStimulus(r, (k % 500) < 450, $urandom_range(0, 3) != 0, 1);
        end

        $display("[TB] reset with queued events and a count in progress");
        applyStimulus(8'h00, 1'b1, 1'b1, 30);
        applyStimulus(8'h07, 1'b1, 1'b0, 10);
        applyStimulus(8'h0F, 1'b1, 1'b0, 4);
        reset_reset_n = 1'b0;
        pd_raw        = 8'h00;
        #1;
        checkOutput("midreset_evt_valid", evt_valid, 0);
        checkOutput("midreset_pd_stable", pd_stable, 0);
        checkOutput("midreset_evt_ch", evt_ch, 0);
        checkOutput("midreset_evt_on", evt_on, 0);
        repeat (3) @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
        applyStimulus(8'h00, 1'b1, 1'b1, 30);

        drain = 0;
        while (exp_q.size() != 0 && drain < 300) begin
            applyStimulus(pd_raw, 1'b1, 1'b1, 1);
            drain++;
        end
        checkOutput("drain_remaining", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
